// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: shadow EX/MEM/WB scoreboard, stall/flush/bubble,
// operand-forwarding selects, data-memory freeze FSM and saturating stall/flush counters.
module hazard_ctrl #(
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 16,
   parameter bit          FWD_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_wb_enable,
   input  logic [REG_W-1:0] id_write_reg,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             id_is_jump,
   input  logic             ex_br_taken,
   input  logic             dmem_ready,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_freeze,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [0:0] {StRun, StMemWait} state_e;

   typedef struct packed {
      logic             valid;
      logic             wb;
      logic             mr;
      logic             mw;
      logic [REG_W-1:0] wreg;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
   } entry_t;

   state_e state_q, state_d;
   entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   logic mem_access, freeze, load_use, raw_stall;

   // Does entry e produce a register value that reg r needs?
   function automatic logic writes_reg(entry_t e, logic [REG_W-1:0] r);
      return e.valid & e.wb & (e.wreg != '0) & (e.wreg == r);
   endfunction

   // A load still in MEM has no data yet, so it never forwards.
   function automatic logic [1:0] fwd_sel(entry_t m, entry_t w, logic [REG_W-1:0] r);
      if (writes_reg(m, r) && !m.mr) return 2'b10;
      if (writes_reg(w, r))          return 2'b01;
      return 2'b00;
   endfunction

   assign mem_access = mem_q.valid & (mem_q.mr | mem_q.mw);
   assign freeze     = ((state_q == StMemWait) | mem_access) & ~dmem_ready;

   assign load_use = id_valid & ex_q.valid & ex_q.mr & (ex_q.wreg != '0) &
                     (((ex_q.wreg == id_rs) & id_uses_rs) | ((ex_q.wreg == id_rt) & id_uses_rt));

   assign raw_stall = !FWD_EN & id_valid &
                      ((id_uses_rs & (writes_reg(ex_q, id_rs) | writes_reg(mem_q, id_rs))) |
                       (id_uses_rt & (writes_reg(ex_q, id_rt) | writes_reg(mem_q, id_rt))));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:     if (mem_access && !dmem_ready) state_d = StMemWait;
         StMemWait: if (dmem_ready) state_d = StRun;
         default:   state_d = StRun;
      endcase
   end

   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_freeze = 1'b0;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
      if (freeze) begin
         pipe_freeze = 1'b1;
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
      end else begin
         if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (load_use || raw_stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
         end else if (id_is_jump && id_valid) begin
            ifid_flush = 1'b1;
         end
         if (ex_q.valid) begin
            fwd_a = fwd_sel(mem_q, wb_q, ex_q.rs);
            fwd_b = fwd_sel(mem_q, wb_q, ex_q.rt);
         end
      end
   end

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!freeze) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         ex_d  = '{valid: id_valid & ~idex_bubble, wb: id_wb_enable, mr: id_mem_read,
                   mw: id_mem_write, wreg: id_write_reg, rs: id_rs, rt: id_rt};
      end
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (pc_stall && stall_cnt_q != '1)   stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (ifid_flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle expected control vectors go through a queue
// and are compared against the DUT at the falling edge.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid, id_uses_rs, id_uses_rt, id_wb_enable, id_mem_read, id_mem_write;
   logic       id_is_jump, ex_br_taken, dmem_ready;
   logic [4:0] id_rs, id_rt, id_write_reg;
   logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze;
   logic [1:0] fwd_a, fwd_b;
   logic [3:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];

   // {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fwd_a, fwd_b}
   localparam logic [8:0] E_NONE   = 9'b00000_00_00;
   localparam logic [8:0] E_LDUSE  = 9'b11010_00_00;
   localparam logic [8:0] E_BRANCH = 9'b00110_00_00;
   localparam logic [8:0] E_FREEZE = 9'b11001_00_00;
   localparam logic [8:0] E_JUMP   = 9'b00100_00_00;

   hazard_ctrl #(.REG_W(5), .CNT_W(4), .FWD_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wb_enable(id_wb_enable),
      .id_write_reg(id_write_reg), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_is_jump(id_is_jump), .ex_br_taken(ex_br_taken), .dmem_ready(dmem_ready),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic wb,
                         input logic [4:0] wr, input logic mr, input logic mw, input logic jmp);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_wb_enable = wb; id_write_reg = wr; id_mem_read = mr; id_mem_write = mw;
      id_is_jump = jmp;
   endtask

   task automatic nop();                         set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic r_op(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      set_id(1, rs, rt, 1, 1, 1, rd, 0, 0, 0);
   endtask
   task automatic lw(input logic [4:0] rt, input logic [4:0] rs);
      set_id(1, rs, rt, 1, 0, 1, rt, 1, 0, 0);
   endtask
   task automatic sw(input logic [4:0] rt, input logic [4:0] rs);
      set_id(1, rs, rt, 1, 1, 0, 0, 0, 1, 0);
   endtask
   task automatic addi(input logic [4:0] rt, input logic [4:0] rs);
      set_id(1, rs, rt, 1, 0, 1, rt, 0, 0, 0);
   endtask
   task automatic jump();                        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask

   // One pipeline cycle: called at posedge+1 with ID already set up.
   task automatic cyc(input string tag, input logic br, input logic rdy, input logic [8:0] exp);
      logic [8:0] want;
      ex_br_taken = br;
      dmem_ready  = rdy;
      exp_q.push_back(exp);
      @(negedge clk);
      want = exp_q.pop_front();
      check_eq(tag, {23'd0, pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze,
                     fwd_a, fwd_b}, {23'd0, want});
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq(tag, {14'd0, pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze,
                     fwd_a, fwd_b, stall_cnt, flush_cnt}, 32'd0);
   endtask

   task automatic do_reset();
      nop();
      ex_br_taken = 0;
      dmem_ready  = 1;
      rst_n = 0;
      #2;
      check_idle_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic drain(input int n);
      nop();
      for (int i = 0; i < n; i++) cyc("drain", 0, 1, E_NONE);
   endtask

   initial begin
      do_reset();

      // lw $2,0($1); add $3,$2,$4
      lw(2, 1);        cyc("t1_lw", 0, 1, E_NONE);
      r_op(3, 2, 4);   cyc("t1_lduse", 0, 1, E_LDUSE);
      r_op(3, 2, 4);   cyc("t1_retry", 0, 1, E_NONE);
      nop();           cyc("t1_fwd", 0, 1, 9'b00000_01_00);
      check_eq("t1_stall_cnt", 32'(stall_cnt), 32'd1);
      drain(3);

      // add $5,$1,$1; sub $6,$5,$5 back-to-back, then with one NOP between
      do_reset();
      r_op(5, 1, 1);   cyc("t2_add", 0, 1, E_NONE);
      r_op(6, 5, 5);   cyc("t2_sub", 0, 1, E_NONE);
      nop();           cyc("t2_fwd_mem", 0, 1, 9'b00000_10_10);
      drain(3);
      r_op(5, 1, 1);   cyc("t2b_add", 0, 1, E_NONE);
      nop();           cyc("t2b_nop", 0, 1, E_NONE);
      r_op(6, 5, 5);   cyc("t2b_sub", 0, 1, E_NONE);
      nop();           cyc("t2b_fwd_wb", 0, 1, 9'b00000_01_01);
      check_eq("t2_stall_cnt", 32'(stall_cnt), 32'd0);
      drain(3);

      // taken branch coinciding with a load-use pair: flush wins
      do_reset();
      lw(2, 1);        cyc("t3_lw", 0, 1, E_NONE);
      r_op(3, 2, 4);   cyc("t3_branch", 1, 1, E_BRANCH);
      nop();           cyc("t3_after", 0, 1, E_NONE);
      check_eq("t3_flush_cnt", 32'(flush_cnt), 32'd1);
      check_eq("t3_stall_cnt", 32'(stall_cnt), 32'd0);
      drain(3);

      // sw in MEM with dmem_ready low 3 cycles; branch held across the freeze
      do_reset();
      sw(2, 1);        cyc("t4_sw", 0, 1, E_NONE);
      nop();           cyc("t4_nop", 0, 1, E_NONE);
      cyc("t4_frz0", 0, 0, E_FREEZE);
      cyc("t4_frz1", 1, 0, E_FREEZE);
      cyc("t4_frz2", 1, 0, E_FREEZE);
      cyc("t4_unfrz_br", 1, 1, E_BRANCH);
      cyc("t4_run", 0, 0, E_NONE);
      check_eq("t4_stall_cnt", 32'(stall_cnt), 32'd3);
      check_eq("t4_flush_cnt", 32'(flush_cnt), 32'd1);
      drain(3);

      // writes to $0 never forward; then a jump costs one flush
      do_reset();
      addi(0, 1);      cyc("t5_addi0", 0, 1, E_NONE);
      r_op(7, 0, 0);   cyc("t5_add", 0, 1, E_NONE);
      nop();           cyc("t5_nofwd", 0, 1, E_NONE);
      jump();          cyc("t5_jump", 0, 1, E_JUMP);
      check_eq("t5_stall_cnt", 32'(stall_cnt), 32'd0);
      check_eq("t5_flush_cnt", 32'(flush_cnt), 32'd1);
      drain(3);

      // saturate stall_cnt during a long MEM_WAIT, then reset mid-wait
      do_reset();
      sw(2, 1);        cyc("t6_sw", 0, 1, E_NONE);
      nop();           cyc("t6_nop", 0, 1, E_NONE);
      for (int i = 0; i < 18; i++) cyc("t6_frz", 0, 0, E_FREEZE);
      check_eq("t6_sat", 32'(stall_cnt), 32'd15);
      rst_n = 0;
      #1;
      check_idle_outputs("t6_rst_mid_wait");
      @(posedge clk);
      #1;
      rst_n = 1;
      cyc("t6_run_after_rst", 0, 0, E_NONE);

      // saturated counter holds at 15 on further stalls
      sw(2, 1);        cyc("t6b_sw", 0, 1, E_NONE);
      nop();           cyc("t6b_nop", 0, 1, E_NONE);
      for (int i = 0; i < 16; i++) cyc("t6b_frz", 0, 0, E_FREEZE);
      check_eq("t6b_sat", 32'(stall_cnt), 32'd15);
      cyc("t6b_frz_more", 0, 0, E_FREEZE);
      cyc("t6b_frz_more", 0, 0, E_FREEZE);
      check_eq("t6b_hold", 32'(stall_cnt), 32'd15);
      cyc("t6b_release", 0, 1, E_NONE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
